// File: rtl/rs_issue_req.sv
// rtl/rs_issue_req.sv - reservation-station issue request/grant tracker with starvation masking
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

module rs_issue_req #(
    parameter int N            = `RS_SIZE,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_en,
    input  logic [$clog2(N)-1:0] alloc_idx,
    input  logic [N-1:0]         wake,
    input  logic [N-1:0]         gnt,
    input  logic                 issue_stall,
    output logic [N-1:0]         req,
    output logic                 en,
    output logic                 issue_valid,
    output logic [$clog2(N)-1:0] issue_idx,
    output logic                 starve,
    output logic                 err
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_ISSUED} ent_t;

    ent_t          state_q [N];
    ent_t          state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic          issue_valid_q, issue_valid_d;
    logic [IW-1:0] issue_idx_q, issue_idx_d;
    logic          err_q, err_d;

    logic [N-1:0]  ready_vec;
    logic [N-1:0]  starved_vec;
    logic [IW-1:0] gnt_idx;
    logic          load;
    logic          gnt_onehot;
    logic          valid_grant;
    logic          retire;

    always_comb begin
        ready_vec   = '0;
        starved_vec = '0;
        gnt_idx     = '0;
        for (int i = 0; i < N; i++) begin
            ready_vec[i]   = (state_q[i] == E_READY);
            starved_vec[i] = (state_q[i] == E_READY) && (cnt_q[i] == LIMIT);
            if (gnt[i]) gnt_idx = IW'(i);
        end
    end

    // Once anything is starved the selector only sees the starved entries.
    assign starve      = |starved_vec;
    assign req         = starve ? starved_vec : ready_vec;
    assign load        = (!issue_valid_q || !issue_stall) && (|ready_vec);
    assign en          = load;
    assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
    assign valid_grant = load && gnt_onehot && ((gnt & ~req) == '0);
    assign retire      = issue_valid_q && !issue_stall;

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign err         = err_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        err_d         = err_q;
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                state_d[i] = E_FREE;
                cnt_d[i]   = '0;
            end
            issue_valid_d = 1'b0;
        end else begin
            if ((gnt != '0) && !valid_grant) err_d = 1'b1;
            if (alloc_en && (state_q[alloc_idx] != E_FREE)) err_d = 1'b1;
            for (int i = 0; i < N; i++) begin
                case (state_q[i])
                    E_FREE:   if (alloc_en && (alloc_idx == IW'(i)))
                                  state_d[i] = wake[i] ? E_READY : E_WAIT;
                    E_WAIT:   if (wake[i]) state_d[i] = E_READY;
                    E_READY:  if (valid_grant && gnt[i]) state_d[i] = E_ISSUED;
                    E_ISSUED: if (retire && (issue_idx_q == IW'(i))) state_d[i] = E_FREE;
                    default:  state_d[i] = E_FREE;
                endcase
                if ((state_q[i] == E_READY) && !(valid_grant && gnt[i]))
                    cnt_d[i] = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + CW'(1);
                else
                    cnt_d[i] = '0;
            end
            // A new grant can land in the same cycle the held issue retires.
            if (valid_grant) begin
                issue_valid_d = 1'b1;
                issue_idx_d   = gnt_idx;
            end else if (retire) begin
                issue_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= E_FREE;
                cnt_q[i]   <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: tb/tb_rs_issue_req.sv
// tb/tb_rs_issue_req.sv - directed scenarios plus random traffic against an entry-table reference model
module tb_rs_issue_req;
    localparam int N  = 8;
    localparam int L  = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset, flush, alloc_en, issue_stall;
    logic [IW-1:0] alloc_idx;
    logic [N-1:0]  wake, gnt, req;
    logic          en, issue_valid, starve, err;
    logic [IW-1:0] issue_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0=free 1=wait 2=ready 3=issued
    int ms [N];
    int mc [N];
    bit miv;
    int midx;
    bit merr;

    always #5 clock = ~clock;

    rs_issue_req #(.N(N), .STARVE_LIMIT(L)) dut (
        .clock(clock), .reset(reset), .flush(flush), .alloc_en(alloc_en),
        .alloc_idx(alloc_idx), .wake(wake), .gnt(gnt), .issue_stall(issue_stall),
        .req(req), .en(en), .issue_valid(issue_valid), .issue_idx(issue_idx),
        .starve(starve), .err(err)
    );

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (ms[i] == 2);
        return r;
    endfunction

    function automatic logic [N-1:0] m_starved();
        logic [N-1:0] s = '0;
        for (int i = 0; i < N; i++) s[i] = (ms[i] == 2) && (mc[i] == L);
        return s;
    endfunction

    function automatic logic [N-1:0] m_req();
        return (m_starved() != '0) ? m_starved() : m_ready();
    endfunction

    function automatic logic m_load(input logic stl);
        return (!miv || !stl) && (m_ready() != '0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req", 32'(req), 32'(m_req()));
        chk("en", 32'(en), 32'(m_load(issue_stall)));
        chk("starve", 32'(starve), 32'(m_starved() != '0));
        chk("issue_valid", 32'(issue_valid), 32'(miv));
        chk("issue_idx", 32'(issue_idx), 32'(midx));
        chk("err", 32'(err), 32'(merr));
    endtask

    task automatic model_step();
        int  ns [N];
        bit  vg;
        logic [N-1:0] r;
        r  = m_req();
        vg = m_load(issue_stall) && ($countones(gnt) == 1) && ((gnt & ~r) == '0);
        if (reset) begin
            for (int i = 0; i < N; i++) begin ms[i] = 0; mc[i] = 0; end
            miv = 0; midx = 0; merr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) begin ms[i] = 0; mc[i] = 0; end
            miv = 0;
        end else begin
            if (gnt != '0 && !vg) merr = 1;
            for (int i = 0; i < N; i++) ns[i] = ms[i];
            if (miv && !issue_stall) ns[midx] = 0;
            for (int i = 0; i < N; i++) begin
                if (alloc_en && int'(alloc_idx) == i) begin
                    if (ms[i] == 0) ns[i] = wake[i] ? 2 : 1;
                    else merr = 1;
                end
                if (ms[i] == 1 && wake[i]) ns[i] = 2;
                if (vg && gnt[i]) ns[i] = 3;
                if (ms[i] == 2 && !(vg && gnt[i])) mc[i] = (mc[i] + 1 > L) ? L : mc[i] + 1;
                else mc[i] = 0;
            end
            for (int i = 0; i < N; i++) ms[i] = ns[i];
            if (vg) begin
                miv = 1;
                for (int i = 0; i < N; i++) if (gnt[i]) midx = i;
            end else if (miv && !issue_stall) begin
                miv = 0;
            end
        end
    endtask

    task automatic drive(input logic ae, input int ai, input logic [N-1:0] wk,
                         input logic [N-1:0] g, input logic stl, input logic fl, input logic rs);
        alloc_en = ae; alloc_idx = IW'(ai); wake = wk; gnt = g;
        issue_stall = stl; flush = fl; reset = rs;
        #1;
    endtask

    task automatic step();
        check_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, '0, 0, 0, 1);
        step();
        drive(0, 0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        int rot [7] = '{0, 1, 3, 4, 5, 6, 7};
        logic [N-1:0] mr, g, wk;
        logic ae, stl, fl, rs;
        int ai, b;
        int fq [$];

        drive(0, 0, '0, '0, 0, 0, 1);
        @(posedge clock);
        model_step();
        #1;
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("rst_iv", 32'(issue_valid), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_starve", 32'(starve), 0);
        chk("rst_idx", 32'(issue_idx), 0);

        // Basic alloc/wake/grant/issue/free
        drive(1, 3, '0, '0, 0, 0, 0); step();
        drive(0, 0, 8'h08, '0, 0, 0, 0); step();
        drive(0, 0, '0, 8'h08, 0, 0, 0);
        chk("s1_req", 32'(req), 32'h08);
        chk("s1_en", 32'(en), 1);
        step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s1_iv", 32'(issue_valid), 1);
        chk("s1_idx", 32'(issue_idx), 3);
        step();
        drive(1, 3, 8'h08, '0, 0, 0, 0); step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s1_realloc_req", 32'(req), 32'h08);
        chk("s1_realloc_err", 32'(err), 0);

        // Stall holds the issue register
        do_reset();
        drive(1, 1, 8'h02, '0, 0, 0, 0); step();
        drive(1, 5, 8'h20, '0, 0, 0, 0); step();
        drive(1, 0, 8'h01, '0, 0, 0, 0); step();
        drive(0, 0, '0, 8'h01, 0, 0, 0); step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, '0, '0, 1, 0, 0);
            chk("s2_en_stall", 32'(en), 0);
            chk("s2_idx_held", 32'(issue_idx), 0);
            step();
        end
        drive(0, 0, '0, 8'h20, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 0, 0);
        chk("s2_idx5", 32'(issue_idx), 5);
        chk("s2_e1_ready", 32'(req[1]), 1);
        step();

        // Starvation of entry 2 while others keep getting granted
        do_reset();
        drive(1, 2, 8'h04, '0, 0, 0, 0); step();
        for (int k = 0; k < 20; k++) begin
            if (m_starved() != '0) break;
            mr = m_req();
            g  = mr & ~8'h04;
            g  = g & (~g + 8'h01);
            drive(1, rot[k % 7], 8'hFF, g, 0, 0, 0);
            step();
        end
        drive(0, 0, '0, 8'h04, 0, 0, 0);
        chk("s3_starve", 32'(starve), 1);
        chk("s3_req", 32'(req), 32'h04);
        step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s3_unstarve", 32'(starve), 0);
        step();

        // Multi-hot grant, sticky err across flush
        do_reset();
        drive(1, 1, 8'h02, '0, 0, 0, 0); step();
        drive(1, 2, 8'h04, '0, 0, 0, 0); step();
        drive(0, 0, '0, 8'h06, 0, 0, 0); step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s4_err", 32'(err), 1);
        chk("s4_req", 32'(req), 32'h06);
        chk("s4_iv", 32'(issue_valid), 0);
        drive(1, 3, 8'hFF, 8'h02, 0, 1, 0); step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s4_err_flush", 32'(err), 1);
        chk("s4_req_flush", 32'(req), 0);
        do_reset();
        chk("s4_err_reset", 32'(err), 0);

        // Alloc collision, then same-cycle alloc+wake
        drive(1, 4, '0, '0, 0, 0, 0); step();
        drive(1, 4, '0, '0, 0, 0, 0); step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s5_err", 32'(err), 1);
        drive(1, 6, 8'h50, '0, 0, 0, 0); step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s5_req", 32'(req), 32'h50);
        step();

        // Reset mid-operation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, k, 8'hFF, '0, 0, 0, 0); step();
        end
        drive(1, 3, 8'h08, 8'h01, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 0, 1);
        chk("s6_pre_iv", 32'(issue_valid), 1);
        step();
        drive(0, 0, '0, '0, 0, 0, 0);
        chk("s6_iv", 32'(issue_valid), 0);
        chk("s6_req", 32'(req), 0);
        chk("s6_en", 32'(en), 0);
        chk("s6_err", 32'(err), 0);
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            fq = {};
            for (int i = 0; i < N; i++) if (ms[i] == 0) fq.push_back(i);
            ae = 1'($urandom_range(0, 1));
            ai = $urandom_range(0, N - 1);
            if (fq.size() > 0 && $urandom_range(0, 99) < 95)
                ai = fq[$urandom_range(0, fq.size() - 1)];
            wk  = N'($urandom) & N'($urandom);
            stl = ($urandom_range(0, 99) < 30);
            mr  = m_req();
            g   = '0;
            if (m_load(stl) && $urandom_range(0, 99) < 85) begin
                for (int t = 0; t < 64; t++) begin
                    b = $urandom_range(0, N - 1);
                    if (mr[b]) begin g[b] = 1'b1; break; end
                end
            end
            if ($urandom_range(0, 99) < 3) g = N'($urandom);
            fl = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 199) == 0);
            drive(ae, ai, wk, g, stl, fl, rs);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
